// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sequencer state encoding, default screen/tile geometry, handshake arm delay.
// Latency: none (package).
// Backpressure: none (package).
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLOR     = 3'd1,
        ST_SPRITE    = 3'd2,
        ST_TILE_GO   = 3'd3,
        ST_TILE_WAIT = 3'd4,
        ST_VBL_WAIT  = 3'd5
    } seq_state_e;

    localparam int DEF_SCREEN_W = 256;
    localparam int DEF_SCREEN_H = 240;
    localparam int DEF_TILE_W   = 8;

    // Cycles after a start pulse during which the matching busy is ignored,
    // giving the sub-FSM time to raise it.
    localparam int ARM_DLY = 2;
    localparam int ARM_W   = 2;

endpackage

// File: rtl/ppu_busy_watchdog.sv
// Busy watchdog: counts cycles spent waiting on a sub-FSM and flags expiry at TIMEOUT_CYC.
// Latency: expire_o is combinational from the count; it asserts in the TIMEOUT_CYC-th wait cycle.
// Backpressure: none; clr_i (a start pulse) restarts the count, run_i holds it counting.
module ppu_busy_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // The start-pulse cycle is itself the first wait cycle, hence the load of 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= CNT_W'(1);
        end else if (run_i && !expire_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_o = run_i && !clr_i && (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ppu_frame_sequencer.sv
// Frame-render sequencer: walks rows/tiles, drives colour/sprite/tile start-busy handshakes, vblank/NMI, frame count.
// Latency: all outputs registered; per tile 2 cycles beyond tile_busy, 2 per row transition.
// Backpressure: each step waits for its sub-FSM busy to drop; a busy held TIMEOUT_CYC cycles abandons the frame.
module ppu_frame_sequencer
    import ppu_pkg::*;
#(
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    parameter int TILE_W        = DEF_TILE_W,
    parameter int COL_W         = 10,
    parameter int ROW_W         = 9,
    parameter int COLOR_PER_ROW = 1,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vga_done_i,
    input  logic             render_en_i,
    input  logic             nmi_en_i,
    input  logic [2:0]       fine_x_i,
    input  logic             status_read_i,
    output logic             color_start_o,
    input  logic             color_busy_i,
    output logic             sprite_start_o,
    input  logic             sprite_busy_i,
    output logic             tile_start_o,
    input  logic             tile_busy_i,
    output logic [ROW_W-1:0] pixel_row_o,
    output logic [COL_W-1:0] pixel_col_o,
    output logic             vblank_o,
    output logic             nmi_o,
    output logic [7:0]       frame_count_o,
    output logic             timeout_err_o
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_W - TILE_W);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_H - 1);

    seq_state_e       state_q;
    logic [ARM_W-1:0] arm_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             vblank_q;
    logic             nmi_q;
    logic [7:0]       frame_cnt_q;
    logic             timeout_q;
    logic             color_start_q;
    logic             sprite_start_q;
    logic             tile_start_q;

    logic [COL_W-1:0] col_first_d;
    logic [COL_W-1:0] col_step_d;
    logic [ROW_W-1:0] row_step_d;
    logic             col_at_last;
    logic             row_at_last;
    logic             waiting;
    logic             busy_sel;
    logic             wait_done;
    logic             wd_expire;

    // A row starts at -fine_x so the scrolled-in partial tile is rendered first.
    assign col_first_d = COL_W'(0) - COL_W'(fine_x_i);
    assign col_step_d  = col_q + COL_W'(TILE_W);
    assign row_step_d  = row_q + ROW_W'(1);
    assign col_at_last = ($signed(col_q) >= $signed(LAST_COL));
    assign row_at_last = (row_q >= LAST_ROW);

    assign waiting = (state_q == ST_COLOR) || (state_q == ST_SPRITE) ||
                     (state_q == ST_TILE_GO) || (state_q == ST_TILE_WAIT);

    // Pick the busy line belonging to the sub-FSM the current state waits on.
    always_comb begin
        busy_sel = 1'b0;
        case (state_q)
            ST_COLOR:     busy_sel = color_busy_i;
            ST_SPRITE:    busy_sel = sprite_busy_i;
            ST_TILE_WAIT: busy_sel = tile_busy_i;
            default:      busy_sel = 1'b0;
        endcase
    end

    assign wait_done = (arm_q == '0) && !busy_sel;

    ppu_busy_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (color_start_q | sprite_start_q | tile_start_q),
        .run_i    (waiting),
        .expire_o (wd_expire)
    );

    // Sequencer FSM with row/column walk, start pulses, vblank/NMI and frame counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            arm_q          <= '0;
            row_q          <= '0;
            col_q          <= '0;
            vblank_q       <= 1'b0;
            nmi_q          <= 1'b0;
            frame_cnt_q    <= '0;
            timeout_q      <= 1'b0;
            color_start_q  <= 1'b0;
            sprite_start_q <= 1'b0;
            tile_start_q   <= 1'b0;
        end else begin
            color_start_q  <= 1'b0;
            sprite_start_q <= 1'b0;
            tile_start_q   <= 1'b0;
            nmi_q          <= 1'b0;
            if (arm_q != '0) begin
                arm_q <= arm_q - ARM_W'(1);
            end
            // A CPU status read clears vblank; any set below overrides it.
            if (status_read_i) begin
                vblank_q <= 1'b0;
            end
            if (waiting && wd_expire) begin
                timeout_q <= 1'b1;
                vblank_q  <= 1'b1;
                nmi_q     <= nmi_en_i;
                state_q   <= ST_VBL_WAIT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (vga_done_i) begin
                            vblank_q <= 1'b0;
                            row_q    <= '0;
                            col_q    <= col_first_d;
                            if (!render_en_i) begin
                                vblank_q <= 1'b1;
                                nmi_q    <= nmi_en_i;
                                state_q  <= ST_VBL_WAIT;
                            end else begin
                                color_start_q <= 1'b1;
                                arm_q         <= ARM_W'(ARM_DLY);
                                state_q       <= ST_COLOR;
                            end
                        end
                    end
                    ST_COLOR: begin
                        if (wait_done) begin
                            sprite_start_q <= 1'b1;
                            arm_q          <= ARM_W'(ARM_DLY);
                            state_q        <= ST_SPRITE;
                        end
                    end
                    ST_SPRITE: begin
                        if (wait_done) begin
                            tile_start_q <= 1'b1;
                            arm_q        <= ARM_W'(ARM_DLY);
                            state_q      <= ST_TILE_GO;
                        end
                    end
                    ST_TILE_GO: begin
                        state_q <= ST_TILE_WAIT;
                    end
                    ST_TILE_WAIT: begin
                        if (wait_done) begin
                            if (!col_at_last) begin
                                col_q        <= col_step_d;
                                tile_start_q <= 1'b1;
                                arm_q        <= ARM_W'(ARM_DLY);
                                state_q      <= ST_TILE_GO;
                            end else if (!row_at_last) begin
                                row_q <= row_step_d;
                                col_q <= col_first_d;
                                arm_q <= ARM_W'(ARM_DLY);
                                if (COLOR_PER_ROW != 0) begin
                                    color_start_q <= 1'b1;
                                    state_q       <= ST_COLOR;
                                end else begin
                                    sprite_start_q <= 1'b1;
                                    state_q        <= ST_SPRITE;
                                end
                            end else begin
                                vblank_q    <= 1'b1;
                                nmi_q       <= nmi_en_i;
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                                state_q     <= ST_VBL_WAIT;
                            end
                        end
                    end
                    ST_VBL_WAIT: begin
                        if (!vga_done_i) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign color_start_o  = color_start_q;
    assign sprite_start_o = sprite_start_q;
    assign tile_start_o   = tile_start_q;
    assign pixel_row_o    = row_q;
    assign pixel_col_o    = col_q;
    assign vblank_o       = vblank_q;
    assign nmi_o          = nmi_q;
    assign frame_count_o  = frame_cnt_q;
    assign timeout_err_o  = timeout_q;

endmodule
